sa_result_drain: RTL and testbench

Downstream drain stage for the systolic array core. Each time the core presents any valid row result, this block captures the whole row bank in one handshake and acknowledges the core with `outread`. It then serializes the captured results onto a single 32-bit valid/ready stream in ascending row order, tagging each beat with its row index and marking the last beat of each frame.

---
 rtl/sa_pkg.sv | 26 ++
 rtl/sa_lowbit_enc.sv | 33 +++
 rtl/sa_result_drain.sv | 150 +++++++++++++++
 tb/tb_sa_result_drain.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sa_pkg
// Description : Shared constants and types for the systolic array core and
//               its result drain stage.
//               ROWS  - number of array rows / result lanes
//               DW    - result word width
//               ROW_W - width of a row index
// Revision    : 1.0 - initial release
// ============================================================================
package sa_pkg;

    localparam int ROWS  = 8;
    localparam int DW    = 32;
    localparam int ROW_W = $clog2(ROWS);

    typedef logic [DW-1:0] row_word_t;

    // Drain controller states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_e;

endpackage : sa_pkg
`default_nettype wire

// File: rtl/sa_lowbit_enc.sv
`default_nettype none
// ============================================================================
// Module      : sa_lowbit_enc
// Description : ROWS-bit lowest-set-bit priority encoder.
// Ports       : vec_i     - input vector, bit 0 has highest priority
//               idx_o     - index of lowest set bit (0 when vec_i == 0)
//               one_hot_o - high when exactly one bit of vec_i is set
// Revision    : 1.0 - initial release
// ============================================================================
module sa_lowbit_enc #(
    parameter int ROWS  = 8,
    parameter int IDX_W = $clog2(ROWS)
) (
    input  logic [ROWS-1:0]  vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             one_hot_o
);

    // Scan from the top down so the lowest set bit is the last to win.
    always_comb begin
        idx_o = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    assign one_hot_o = (vec_i != '0) && ((vec_i & (vec_i - 1'b1)) == '0);

endmodule : sa_lowbit_enc
`default_nettype wire

// File: rtl/sa_result_drain.sv
`default_nettype none
// ============================================================================
// Module      : sa_result_drain
// Description : Captures the systolic array's row result bank in a single
//               handshake, then serializes the valid rows in ascending row
//               order onto a valid/ready stream.
// Ports       : clk        - rising-edge clock
//               rst        - asynchronous active-high reset
//               routport   - per-row result words [0:ROWS-1]
//               rvalidport - per-row result valids, bit i <-> routport[i]
//               outread    - capture acknowledge to the core
//               m_data     - serialized result word
//               m_row      - row index of m_data
//               m_last     - final beat of a frame
//               m_valid    - stream valid
//               m_ready    - stream ready
//               frame_cnt  - completed frame count (wraps at 16 bits)
// Revision    : 1.0 - initial release
// ============================================================================
module sa_result_drain #(
    parameter int ROWS = sa_pkg::ROWS,
    parameter int DW   = sa_pkg::DW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DW-1:0]            routport [0:ROWS-1],
    input  logic [0:ROWS-1]          rvalidport,
    output logic                     outread,
    output logic [DW-1:0]            m_data,
    output logic [$clog2(ROWS)-1:0]  m_row,
    output logic                     m_last,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [15:0]              frame_cnt
);

    import sa_pkg::*;

    localparam int IDX_W = $clog2(ROWS);

    drain_state_e     state_q, state_d;
    logic [ROWS-1:0]  mask_q, mask_d;
    logic [ROWS-1:0]  w_valid_vec;
    logic [DW-1:0]    bank_q [ROWS];
    logic [DW-1:0]    hold_data_q;
    logic [IDX_W-1:0] hold_row_q;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [IDX_W-1:0] w_idx;
    logic             w_one_hot;
    logic             w_capture;

    // rvalidport is ascending-indexed; remap so that mask bit i is row i.
    always_comb begin
        w_valid_vec = '0;
        for (int i = 0; i < ROWS; i++) begin
            w_valid_vec[i] = rvalidport[i];
        end
    end

    sa_lowbit_enc #(
        .ROWS  (ROWS),
        .IDX_W (IDX_W)
    ) u_lowbit_enc (
        .vec_i     (mask_q),
        .idx_o     (w_idx),
        .one_hot_o (w_one_hot)
    );

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        frame_cnt_d = frame_cnt_q;
        outread     = 1'b0;
        m_valid     = 1'b0;
        m_last      = 1'b0;
        w_capture   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // rst gates the acknowledge so the core never retires
                // results while this block is being reset.
                outread = (w_valid_vec != '0) && !rst;
                if (outread) begin
                    w_capture = 1'b1;
                    mask_d    = w_valid_vec;
                    state_d   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                m_valid = !rst;
                m_last  = w_one_hot && !rst;
                if (m_ready) begin
                    mask_d[w_idx] = 1'b0;
                    if (w_one_hot) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Data and row come straight from the bank while draining; in IDLE they
    // show the last presented beat.
    assign m_data    = (state_q == ST_DRAIN) ? bank_q[w_idx] : hold_data_q;
    assign m_row     = (state_q == ST_DRAIN) ? w_idx : hold_row_q;
    assign frame_cnt = frame_cnt_q;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            frame_cnt_q <= '0;
            hold_data_q <= '0;
            hold_row_q  <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            frame_cnt_q <= frame_cnt_d;
            if (state_q == ST_DRAIN) begin
                hold_data_q <= bank_q[w_idx];
                hold_row_q  <= w_idx;
            end
        end
    end

    // The whole bank is latched, including rows that will never be emitted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) begin
                bank_q[i] <= '0;
            end
        end else if (w_capture) begin
            for (int i = 0; i < ROWS; i++) begin
                bank_q[i] <= routport[i];
            end
        end
    end

endmodule : sa_result_drain
`default_nettype wire

// File: tb/tb_sa_result_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_sa_result_drain
// Description : Self-checking bench for sa_result_drain. A queue-based model
//               turns every acknowledged capture into the list of expected
//               (row, data) beats and pops one beat per accepted handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sa_result_drain;

    localparam int NR = 8;
    localparam int W  = 32;

    logic            clk;
    logic            rst;
    logic [W-1:0]    routport [0:NR-1];
    logic [0:NR-1]   rvalidport;
    logic            outread;
    logic [W-1:0]    m_data;
    logic [2:0]      m_row;
    logic            m_last;
    logic            m_valid;
    logic            m_ready;
    logic [15:0]     frame_cnt;

    sa_result_drain #(
        .ROWS (NR),
        .DW   (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .routport   (routport),
        .rvalidport (rvalidport),
        .outread    (outread),
        .m_data     (m_data),
        .m_row      (m_row),
        .m_last     (m_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   row;
        logic [W-1:0] data;
    } beat_t;

    beat_t        exp_q[$];
    logic [15:0]  mdl_cnt;
    logic [W-1:0] mdl_ldata;
    logic [2:0]   mdl_lrow;
    int           vec_cnt;
    int           err_cnt;
    int           capt_cnt;
    int           beat_cnt;
    int           cyc;
    int           capt_cyc[$];
    bit           stall_prev;
    logic [W-1:0] st_data;
    logic [2:0]   st_row;
    logic         st_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        mdl_cnt    = '0;
        mdl_ldata  = '0;
        mdl_lrow   = '0;
        stall_prev = 1'b0;
    endtask

    // One clock: check outputs at the falling edge, advance the model for
    // the coming rising edge, and return just after that edge.
    task automatic step();
        @(negedge clk);
        if (rst) begin
            chk("rst_outread", outread, 0);
            chk("rst_m_valid", m_valid, 0);
            chk("rst_frame_cnt", frame_cnt, 0);
            chk("rst_m_data", m_data, 0);
        end else begin
            chk("frame_cnt", frame_cnt, mdl_cnt);
            if (stall_prev) begin
                chk("hold_data", m_data, st_data);
                chk("hold_row", m_row, st_row);
                chk("hold_last", m_last, st_last);
            end
            stall_prev = 1'b0;
            if (exp_q.size() == 0) begin
                chk("idle_outread", outread, |rvalidport);
                chk("idle_m_valid", m_valid, 0);
                chk("idle_m_last", m_last, 0);
                chk("idle_m_data", m_data, mdl_ldata);
                chk("idle_m_row", m_row, mdl_lrow);
                if (|rvalidport) begin
                    capt_cnt++;
                    capt_cyc.push_back(cyc);
                    for (int i = 0; i < NR; i++) begin
                        if (rvalidport[i]) begin
                            exp_q.push_back('{row: 3'(i), data: routport[i]});
                        end
                    end
                end
            end else begin
                chk("drain_outread", outread, 0);
                chk("m_valid", m_valid, 1);
                chk("m_data", m_data, exp_q[0].data);
                chk("m_row", m_row, exp_q[0].row);
                chk("m_last", m_last, exp_q.size() == 1);
                if (m_ready) begin
                    mdl_ldata = exp_q[0].data;
                    mdl_lrow  = exp_q[0].row;
                    void'(exp_q.pop_front());
                    beat_cnt++;
                    if (exp_q.size() == 0) mdl_cnt = mdl_cnt + 16'd1;
                end else begin
                    stall_prev = 1'b1;
                    st_data    = m_data;
                    st_row     = m_row;
                    st_last    = m_last;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain_out(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain_budget", exp_q.size(), 0);
    endtask

    task automatic load_full();
        for (int i = 0; i < NR; i++) routport[i] = 32'(100 + i);
        rvalidport = '1;
    endtask

    int c0;
    int b0;
    int d;

    initial begin
        vec_cnt  = 0;
        err_cnt  = 0;
        capt_cnt = 0;
        beat_cnt = 0;
        cyc      = 0;
        model_reset();
        rst        = 1'b1;
        m_ready    = 1'b0;
        rvalidport = '0;
        for (int i = 0; i < NR; i++) routport[i] = '0;
        step();
        rvalidport = '1;
        step();
        rst        = 1'b0;
        rvalidport = '0;
        step();

        // Full frame, no backpressure
        m_ready = 1'b1;
        load_full();
        c0 = capt_cnt;
        b0 = beat_cnt;
        step();
        rvalidport = '0;
        for (int i = 0; i < NR; i++) step();
        step();
        chk("full_outread_pulses", capt_cnt - c0, 1);
        chk("full_beats", beat_cnt - b0, 8);
        chk("full_frame_cnt", frame_cnt, 1);

        // Sparse mask held high: rows 0, 5, 7
        for (int i = 0; i < NR; i++) routport[i] = $urandom;
        routport[0] = 32'hA;
        routport[5] = 32'hB;
        routport[7] = 32'hC;
        rvalidport = '0;
        rvalidport[0] = 1'b1;
        rvalidport[5] = 1'b1;
        rvalidport[7] = 1'b1;
        capt_cyc.delete();
        b0 = beat_cnt;
        for (int i = 0; i < 5; i++) step();
        chk("sparse_capt_count", capt_cyc.size(), 2);
        d = (capt_cyc.size() >= 2) ? capt_cyc[1] - capt_cyc[0] : -1;
        chk("sparse_period", d, 4);
        rvalidport = '0;
        drain_out(10);
        chk("sparse_beats", beat_cnt - b0, 6);

        // Backpressure 1,0,0 pattern
        load_full();
        b0 = beat_cnt;
        step();
        rvalidport = '0;
        for (int n = 0; n < 60 && exp_q.size() != 0; n++) begin
            m_ready = (n % 3 == 0);
            step();
        end
        chk("bp_done", exp_q.size(), 0);
        chk("bp_beats", beat_cnt - b0, 8);
        m_ready = 1'b1;
        step();

        // Valid held high during drain
        load_full();
        c0 = capt_cnt;
        for (int i = 0; i < 12; i++) step();
        chk("vdd_outread_pulses", capt_cnt - c0, 2);
        rvalidport = '0;
        drain_out(12);
        step();

        // Reset mid-drain after beat 3
        load_full();
        step();
        rvalidport = '0;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
        rvalidport = '1;
        #1;
        chk("async_m_valid", m_valid, 0);
        chk("async_outread", outread, 0);
        chk("async_frame_cnt", frame_cnt, 0);
        model_reset();
        step();
        rst = 1'b0;
        for (int i = 0; i < NR; i++) routport[i] = 32'(200 + i);
        step();
        rvalidport = '0;
        chk("post_rst_row", m_row, 0);
        chk("post_rst_data", m_data, 200);
        drain_out(12);
        step();

        // Counter wrap
        force dut.frame_cnt_q = 16'hFFFF;
        mdl_cnt = 16'hFFFF;
        step();
        release dut.frame_cnt_q;
        step();
        rvalidport = '0;
        rvalidport[3] = 1'b1;
        routport[3] = 32'hDEAD_BEEF;
        step();
        rvalidport = '0;
        drain_out(4);
        step();
        chk("wrap_frame_cnt", frame_cnt, 0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NR; i++) routport[i] = $urandom;
            rvalidport = ($urandom_range(0, 3) == 0) ? '0 : NR'($urandom);
            m_ready    = ($urandom_range(0, 3) != 0);
            step();
        end
        rvalidport = '0;
        m_ready    = 1'b1;
        drain_out(20);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_sa_result_drain
`default_nettype wire
